// File: rtl/monitor_contador.sv
// monitor_contador
//   Passive sequence checker for the 8-bit up/down counter. Each valid sample
//   of q is compared against a prediction built from the previous accepted
//   sample and the direction (mode) sampled alongside q. It reports
//   mismatches, wrap-arounds, error/wrap counts and lock/loss of sequence.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   valid      : sample q/mode this edge when 1
//   q          : observed counter value (WIDTH)
//   mode       : observed direction, 0 = up, 1 = down
//   locked     : 1 while tracking the sequence
//   lost       : sticky, set when MAX_MISS consecutive mismatches are seen
//   mismatch   : one-cycle pulse per mismatched sample
//   wrap       : one-cycle pulse per correctly predicted wrap-around sample
//   err_count  : saturating mismatch count (8 bits)
//   wrap_count : saturating wrap count (16 bits)
module monitor_contador #(
    parameter int WIDTH    = 8,
    parameter int MAX_MISS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             locked,
    output logic             lost,
    output logic             mismatch,
    output logic             wrap,
    output logic [7:0]       err_count,
    output logic [15:0]      wrap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } state_t;

    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    state_t           state;
    logic [WIDTH-1:0] ref_val;
    logic [3:0]       miss_run;

    logic [WIDTH-1:0] exp_val;
    logic             hit;
    logic             wrap_hit;
    logic [3:0]       miss_next;

    // Direction comes from the current sample, so turning around is legal
    // at any point in the sequence.
    assign exp_val   = mode ? (ref_val - WIDTH'(1)) : (ref_val + WIDTH'(1));
    assign hit       = (q == exp_val);
    assign wrap_hit  = mode ? (q == {WIDTH{1'b1}}) : (q == '0);
    assign miss_next = miss_run + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ref_val    <= '0;
            miss_run   <= '0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            if (valid) begin
                // The monitor always follows the observed sequence, so a
                // single glitch costs two mismatches (glitch and return).
                ref_val <= q;
                case (state)
                    TRACK: begin
                        if (hit) begin
                            miss_run <= '0;
                            if (wrap_hit) begin
                                wrap <= 1'b1;
                                if (wrap_count != 16'hFFFF)
                                    wrap_count <= wrap_count + 16'd1;
                            end
                        end else begin
                            mismatch <= 1'b1;
                            miss_run <= miss_next;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                            if (miss_next == MISS_LIMIT) begin
                                state  <= LOST;
                                locked <= 1'b0;
                                lost   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and LOST both resync on the next sample
                        // without comparing it.
                        miss_run <= '0;
                        state    <= TRACK;
                        locked   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_monitor_contador.sv
module tb_monitor_contador;

    localparam int MAX_MISS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  q = '0;
    logic        mode = 1'b0;
    logic        locked, lost, mismatch, wrap;
    logic [7:0]  err_count;
    logic [15:0] wrap_count;

    int errors = 0;
    int checks = 0;

    monitor_contador #(.WIDTH(8), .MAX_MISS(MAX_MISS)) dut (
        .clk(clk), .reset(reset), .valid(valid), .q(q), .mode(mode),
        .locked(locked), .lost(lost), .mismatch(mismatch), .wrap(wrap),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    // Reference model: "synced" means a reference value is held and being
    // compared against; IDLE and LOST are both simply "not synced".
    bit m_sync, m_lost, e_mis, e_wrap;
    int m_ref, m_miss, m_err, m_wrap;

    wire [27:0] obs = {locked, lost, mismatch, wrap, err_count, wrap_count};

    function automatic logic [27:0] expv();
        return {m_sync, m_lost, e_mis, e_wrap, 8'(m_err), 16'(m_wrap)};
    endfunction

    function automatic void model_reset();
        m_sync = 0; m_lost = 0; e_mis = 0; e_wrap = 0;
        m_ref = 0; m_miss = 0; m_err = 0; m_wrap = 0;
    endfunction

    function automatic void model(bit v, int s, bit m);
        int pred;
        e_mis = 0; e_wrap = 0;
        if (!v) return;
        if (!m_sync) begin
            m_ref = s; m_miss = 0; m_sync = 1;
            return;
        end
        pred = m ? (m_ref + 255) % 256 : (m_ref + 1) % 256;
        if (s == pred) begin
            m_miss = 0;
            if (s == (m ? 255 : 0)) begin
                e_wrap = 1;
                if (m_wrap < 65535) m_wrap++;
            end
        end else begin
            e_mis = 1;
            if (m_err < 255) m_err++;
            m_miss++;
            if (m_miss == MAX_MISS) begin
                m_sync = 0;
                m_lost = 1;
            end
        end
        m_ref = s;
    endfunction

    // Drive one cycle and advance the model; checks are done by the caller.
    task automatic apply(bit v, int s, bit m);
        valid = v; q = 8'(s); mode = m;
        @(posedge clk); #1;
        model(v, s, m);
    endtask

    task automatic do_reset();
        reset = 1; valid = 1; q = 8'($urandom); mode = 1'($urandom);
        @(posedge clk); #1;
        reset = 0; valid = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 28'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
    endtask

    task automatic test_upcount();
        do_reset();
        for (int i = 0; i <= 256; i++) begin
            apply(1, i % 256, 0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL upcount[%0d] got=%h want=%h", i, obs, expv());
            end
            checks++;
            if (mismatch !== 1'b0 || locked !== 1'b1 || wrap !== (i == 256)) begin
                errors++;
                $display("FAIL upcount_flags[%0d] got mis=%b lock=%b wrap=%b", i, mismatch, locked, wrap);
            end
        end
        checks++;
        if (wrap_count !== 16'd1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL upcount_totals got wc=%0d ec=%0d want wc=1 ec=0", wrap_count, err_count);
        end
    endtask

    task automatic test_down();
        int seq [6] = '{3, 2, 1, 0, 255, 254};
        bit wexp [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1, seq[i], 1);
            checks++;
            if (obs !== expv() || wrap !== wexp[i]) begin
                errors++;
                $display("FAIL down[%0d] got=%h want=%h wrap_want=%b", i, obs, expv(), wexp[i]);
            end
        end
        checks++;
        if (wrap_count !== 16'd1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL down_totals got wc=%0d ec=%0d want wc=1 ec=0", wrap_count, err_count);
        end
    endtask

    task automatic test_glitch();
        int seq [4] = '{10, 11, 50, 13};
        bit mexp [4] = '{0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1, seq[i], 0);
            checks++;
            if (obs !== expv() || mismatch !== mexp[i] || locked !== 1'b1) begin
                errors++;
                $display("FAIL glitch[%0d] got=%h want=%h mis_want=%b", i, obs, expv(), mexp[i]);
            end
        end
        checks++;
        if (err_count !== 8'd2) begin
            errors++;
            $display("FAIL glitch_errcount got=%0d want=2", err_count);
        end
    endtask

    task automatic test_lost();
        int seq [7] = '{19, 20, 20, 20, 20, 20, 40};
        bit mexp [7] = '{0, 0, 1, 1, 1, 1, 0};
        bit lexp [7] = '{1, 1, 1, 1, 1, 0, 1};
        bit sexp [7] = '{0, 0, 0, 0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(1, seq[i], 0);
            checks++;
            if (obs !== expv() || mismatch !== mexp[i] || locked !== lexp[i] || lost !== sexp[i]) begin
                errors++;
                $display("FAIL lost[%0d] got=%h want=%h (mis=%b lock=%b lost=%b)",
                         i, obs, expv(), mexp[i], lexp[i], sexp[i]);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        apply(1, 5, 0);
        apply(1, 6, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 99, 0);
            checks++;
            if (obs !== expv() || locked !== 1'b1 || mismatch !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d] got=%h want=%h", i, obs, expv());
            end
        end
        apply(1, 7, 0);
        checks++;
        if (obs !== expv() || mismatch !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL gap_resume got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_midreset();
        do_reset();
        apply(1, 1, 0);
        apply(1, 5, 0);
        apply(1, 9, 0);
        apply(1, 13, 0);
        checks++;
        if (err_count !== 8'd3 || obs !== expv()) begin
            errors++;
            $display("FAIL midreset_setup got=%h want=%h", obs, expv());
        end
        do_reset();
        checks++;
        if (obs !== 28'd0) begin
            errors++;
            $display("FAIL midreset_clear got=%h want=0", obs);
        end
        apply(1, 77, 1);
        checks++;
        if (obs !== expv() || mismatch !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first got=%h want=%h", obs, expv());
        end
    endtask

    task automatic test_random();
        int cnt = 0;
        bit m, v;
        int s;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
                checks++;
                if (obs !== 28'd0) begin
                    errors++;
                    $display("FAIL random_reset[%0d] got=%h", i, obs);
                end
                continue;
            end
            v = ($urandom_range(9) < 8);
            m = ($urandom_range(9) < 2) ? ~mode : mode;
            if (v) cnt = m ? (cnt + 255) % 256 : (cnt + 1) % 256;
            s = ($urandom_range(9) < 8) ? cnt : int'($urandom_range(255));
            if (v) cnt = s;
            apply(v, s, m);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random[%0d] got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            apply(1, int'($urandom_range(255)), 1'($urandom));
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL errsat[%0d] got=%h want=%h", i, obs, expv());
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL errsat_final got=%0d want=255", err_count);
        end
    endtask

    // Alternating 255/0 with the matching direction wraps on every sample.
    task automatic test_wrap_saturation();
        do_reset();
        apply(1, 255, 0);
        for (int i = 0; i < 65540; i++) begin
            if (i % 2 == 0) apply(1, 0, 0);
            else            apply(1, 255, 1);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL wrapsat[%0d] got=%h want=%h", i, obs, expv());
            end
        end
        checks++;
        if (wrap_count !== 16'hFFFF || wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrapsat_final got wc=%0d wrap=%b want wc=65535 wrap=1", wrap_count, wrap);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_upcount();
        test_down();
        test_glitch();
        test_lost();
        test_gap();
        test_midreset();
        test_random();
        test_err_saturation();
        test_wrap_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/monitor_contador.md
# monitor_contador

Passive checker sitting directly downstream of the 8-bit up/down counter (`contador`). It samples the counter output `q` together with its `mode` and predicts each next value. It flags mismatches, counts errors and wrap-arounds, and tracks lock/loss of sequence. The block is synthesizable and lets counter-sequence checking run in hardware or in emulation alongside the bench.

## Interface
- `WIDTH`, default 8: width of the observed counter value.
- `MAX_MISS`, default 4: number of consecutive mismatches that forces state LOST (legal range 1..15).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset; one clock, one reset.
- `valid` in 1: when 1, `q` and `mode` are sampled this edge; when 0, the cycle is ignored.
- `q` in WIDTH: observed counter value.
- `mode` in 1: observed counter direction; 0 = up (+1), 1 = down (−1).
- `locked` out 1: 1 while in state TRACK.
- `lost` out 1: sticky; set on entry to LOST, cleared only by `reset`.
- `mismatch` out 1: one-cycle pulse when a sample differs from the prediction.
- `wrap` out 1: one-cycle pulse when a correctly predicted sample wraps.
- `err_count` out 8: number of mismatches, saturating at 255.
- `wrap_count` out 16: number of wraps, saturating at 65535.

## Operation
- Internal registers:
  - `ref`: last accepted sample, WIDTH bits.
  - `miss_run`: consecutive-mismatch counter, 4 bits.
  - `state`: one of IDLE, TRACK, LOST.
- Prediction: `exp = ref + 1` if the sampled `mode` = 0, else `ref − 1`. Arithmetic is modulo 2^WIDTH. The `mode` used is the one sampled with the current `q`, so a direction change is legal at any sample.
- IDLE, on a valid sample:
  - `ref <= q`, `miss_run <= 0`, go to TRACK.
  - No comparison is made.
- TRACK, on a valid sample:
  - Compare `q` with `exp`.
  - Always `ref <= q`, so the monitor follows the actual sequence. A single glitch therefore produces two mismatches: the glitch and the return.
  - On match: `miss_run <= 0`. If (`mode` = 0 and `q` = 0) or (`mode` = 1 and `q` = 2^WIDTH−1), pulse `wrap` and increment `wrap_count`.
  - On mismatch: pulse `mismatch`, increment `err_count`, increment `miss_run`. If the new `miss_run` equals MAX_MISS, go to LOST and set `lost`.
  - A mismatched sample never generates `wrap`.
- LOST:
  - `locked` = 0.
  - The next valid sample resyncs without comparison: `ref <= q`, `miss_run <= 0`, go to TRACK.
- `valid` = 0: all registers hold; `mismatch` and `wrap` are 0.
- Saturation: once a counter reaches its maximum it holds; further events still pulse `mismatch`/`wrap`.
- A counter reset to 0 while tracking is treated as an ordinary sample. For example, 0x37 followed by 0x00 in up mode is one mismatch.

## Timing
- All outputs are registered. The effect of the sample taken at edge N is visible after edge N (readable before edge N+1); latency is 1 cycle.
- `mismatch` and `wrap` are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples keep the pulse high on consecutive cycles.
- `locked` rises in the cycle after the first valid sample following reset or LOST.
- `locked` falls in the cycle after the MAX_MISS-th consecutive mismatch; `lost` rises in the same cycle.
- Reset, at any time including mid-sequence, takes effect at the next edge:
  - state = IDLE, `ref` = 0, `miss_run` = 0.
  - `locked`, `lost`, `mismatch`, `wrap` = 0.
  - `err_count` = 0, `wrap_count` = 0.
  - `valid` is ignored while `reset` = 1.
- With `reset` and `valid` both high on the same edge, reset wins and the sample is discarded.

## Test plan
- Reset, then valid up-count samples 0..255,0 with `mode`=0:
  - `locked`=1 from the cycle after sample 0.
  - `mismatch` is never asserted.
  - A single `wrap` pulse occurs after the final 0; `wrap_count`=1, `err_count`=0.
- `mode`=1 samples 3,2,1,0,255,254:
  - A `wrap` pulse occurs after the 255 sample only.
  - `wrap_count`=1, `err_count`=0.
- Up-mode samples 10,11,50,13:
  - `mismatch` pulses after 50 (expected 12) and after 13 (expected 51).
  - `err_count`=2 and `locked` stays 1.
- Up-mode samples 19,20,20,20,20,20 with MAX_MISS=4:
  - Four mismatches; after the last one `locked`=0 and `lost`=1.
  - Next sample 40: `locked`=1 with no `mismatch`, and `lost` stays 1.
- Up-mode samples 5,6 with three `valid`=0 cycles holding `q`=99 between them, then 7:
  - No mismatch; the monitor state is unchanged across the gap.
- Mid-sequence reset with `err_count`=3 and `valid` also high:
  - After the edge all outputs are 0 and the state is IDLE.
  - The next valid sample produces no `mismatch`.
